// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/ALU encodings, controller states and the decoded-instruction
// record used by the cpu_ctrl slice.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_MOVB = 4'h7;
    localparam logic [3:0] OP_STA  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_MOVA = 3'b100;
    localparam logic [2:0] ALU_MOVB = 3'b101;

    typedef struct packed {
        logic       is_alu;
        logic [2:0] alu_op;
        logic       is_mem;
        logic       is_store;
        logic       is_jmp;
        logic       is_jz;
        logic       is_hlt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Memory request/ready bus between the controller (master) and the shared
// program/data memory (slave).
interface cpu_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/cpu_decode.sv
// Combinational opcode classifier; undefined opcodes (B-E) flag is_illegal only.
module cpu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_MOVA;
        case (opcode)
            OP_NOP:  ;
            OP_LDA,
            OP_LDB:  dec.is_mem = 1'b1;
            OP_ADD:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD;  end
            OP_SUB:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB;  end
            OP_AND:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND;  end
            OP_OR:   begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;   end
            OP_MOVB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_MOVB; end
            OP_STA:  begin dec.is_mem = 1'b1; dec.is_store = 1'b1;   end
            OP_JMP:  dec.is_jmp = 1'b1;
            OP_JZ:   dec.is_jz  = 1'b1;
            OP_HLT:  dec.is_hlt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller: owns PC, IR and the zero flag,
// sequences the memory bus and drives the A/B load strobes and ALU op.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    cpu_ctrl_if.master        bus,
    output logic [2:0]        alu_op,
    input  logic              alu_zero,
    output logic              a_load,
    output logic              a_sel,
    output logic              b_load,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic              z_flag;
    dec_t              dec;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              mem_done;

    assign opcode   = ir[DATA_W-1 -: 4];
    assign ir_addr  = ir[ADDR_W-1:0];
    assign mem_done = (state == S_MEM) && bus.mem_ready;

    cpu_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            z_flag  <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir    <= bus.mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec.is_alu)      state <= S_EXEC;
                    else if (dec.is_mem) state <= S_MEM;
                    else if (dec.is_hlt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        // Jumps, NOP and illegal opcodes all return to FETCH.
                        if (dec.is_jmp || (dec.is_jz && z_flag)) pc <= ir_addr;
                        if (dec.is_illegal) illegal <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    z_flag <= alu_zero;
                    state  <= S_FETCH;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (opcode == OP_LDA) z_flag <= (bus.mem_rdata == '0);
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus and ALU op are Moore on state/ir; only the MEM load strobes see mem_ready.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        alu_op       = ALU_MOVA;
        a_load       = 1'b0;
        a_sel        = 1'b0;
        b_load       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc;
            end
            S_EXEC: begin
                alu_op = dec.alu_op;
                a_load = 1'b1;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = dec.is_store;
                bus.mem_addr = ir_addr;
                a_load       = mem_done && (opcode == OP_LDA);
                a_sel        = mem_done && (opcode == OP_LDA);
                b_load       = mem_done && (opcode == OP_LDB);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: memory with programmable ready delay, a small
// A/B/ALU datapath, and hand-computed expectations checked by assertions.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       a_load, a_sel, b_load;
    logic [3:0] pc;
    logic       halted, illegal;

    cpu_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    cpu_ctrl #(.ADDR_W(4), .DATA_W(8), .RESET_PC(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .bus      (bus),
        .alu_op   (alu_op),
        .alu_zero (alu_zero),
        .a_load   (a_load),
        .a_sel    (a_sel),
        .b_load   (b_load),
        .pc       (pc),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Memory: read-only image, ready after dly wait cycles per access
    logic [7:0] mem [16];
    int         dly = 0;
    int         wcnt = 0;
    assign bus.mem_ready = bus.mem_req && (wcnt >= dly);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ready) wcnt <= 0;
        else                               wcnt <= wcnt + 1;
    end

    // Datapath: A/B registers and ALU
    logic [7:0] ra = 8'h00, rb = 8'h00, y;
    always_comb begin
        case (alu_op)
            3'b000:  y = ra + rb;
            3'b001:  y = ra - rb;
            3'b010:  y = ra & rb;
            3'b011:  y = ra | rb;
            3'b101:  y = rb;
            default: y = ra;
        endcase
    end
    assign alu_zero = (y == 8'h00);

    always @(posedge clk) begin
        if (a_load) ra <= a_sel ? bus.mem_rdata : y;
        if (b_load) rb <= bus.mem_rdata;
    end

    int total = 0, bad = 0;
    int cyc, ex_cnt, ex_bad, lda_cnt, b_cnt, st_cnt, strobe_bad, hold_bad;
    logic [7:0] lda_data, b_data, st_data;
    logic [3:0] st_addr, prev_addr;
    logic [2:0] ex_op;
    logic       prev_wait, prev_we;
    logic [3:0] rd_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; ex_cnt = 0; ex_bad = 0; lda_cnt = 0; b_cnt = 0; st_cnt = 0;
        strobe_bad = 0; hold_bad = 0; prev_wait = 1'b0; prev_we = 1'b0;
        prev_addr = '0; ex_op = 3'b100; lda_data = '0; b_data = '0;
        st_data = '0; st_addr = '0;
        rd_q.delete();
    endtask

    // Advance to the next falling edge and record what the DUT shows there
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.mem_req && !bus.mem_we && bus.mem_ready) rd_q.push_back(bus.mem_addr);
        if (alu_op != 3'b100) begin
            ex_cnt++;
            ex_op = alu_op;
            if (!a_load || a_sel) ex_bad++;
        end
        if (a_load && a_sel) begin
            lda_cnt++; lda_data = bus.mem_rdata;
            if (!bus.mem_ready) strobe_bad++;
        end
        if (b_load) begin
            b_cnt++; b_data = bus.mem_rdata;
            if (!bus.mem_ready) strobe_bad++;
        end
        if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
            st_cnt++; st_addr = bus.mem_addr; st_data = ra;
        end
        if (prev_wait && (!bus.mem_req || bus.mem_addr != prev_addr || bus.mem_we != prev_we))
            hold_bad++;
        prev_wait = bus.mem_req && !bus.mem_ready;
        prev_addr = bus.mem_addr;
        prev_we   = bus.mem_we;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic load_base(input logic [7:0] i2);
        clear_mem();
        mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = i2; mem[3] = 8'h8C;
        mem[4] = 8'hF0; mem[10] = 8'h05; mem[11] = 8'h03;
    endtask

    // Pulse run, then count cycles until halted (bounded)
    task automatic go();
        clear_mon();
        run = 1'b1;
        step();
        run = 1'b0;
        cyc = 0;
        while (!halted && cyc < 300) step();
    endtask

    logic [3:0] op_tab  [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    logic [2:0] alu_tab [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    logic [7:0] res_tab [4] = '{8'h02, 8'h01, 8'h07, 8'h03};
    logic [3:0] exp5    [7] = '{4'h0, 4'h1, 4'hD, 4'h2, 4'hF, 4'h0, 4'h4};

    initial begin
        int n;
        clear_mon();
        clear_mem();
        do_reset();
        // Reset state
        chk("rst_req",    bus.mem_req, 1'b0);
        chk("rst_we",     bus.mem_we, 1'b0);
        chk("rst_addr",   bus.mem_addr, 4'h0);
        chk("rst_strobe", {a_load, b_load, a_sel}, 3'b000);
        chk("rst_aluop",  alu_op, 3'b100);
        chk("rst_pc",     pc, 4'h0);
        chk("rst_flags",  {halted, illegal}, 2'b00);
        step(); step();
        chk("idle_req", bus.mem_req, 1'b0);

        // 1: LDA A, LDB B, ADD, STA C, HLT with ready always high
        load_base(8'h30);
        dly = 0;
        go();
        chk("t1_halt",   halted, 1'b1);
        chk("t1_cycles", cyc, 14);
        chk("t1_lda",    {lda_cnt[7:0], lda_data}, {8'd1, 8'h05});
        chk("t1_ldb",    {b_cnt[7:0], b_data}, {8'd1, 8'h03});
        chk("t1_exec",   {ex_cnt[7:0], 5'd0, ex_op}, {8'd1, 8'h00});
        chk("t1_sta",    {st_cnt[7:0], 4'h0, st_addr, st_data}, {8'd1, 8'h0C, 8'h08});
        chk("t1_pc",     pc, 4'h5);
        chk("t1_ill",    illegal, 1'b0);

        // 2: SUB/AND/OR/MOVB substituted at address 2
        for (int k = 0; k < 4; k++) begin
            do_reset();
            load_base({op_tab[k], 4'h0});
            go();
            chk($sformatf("t2_%0d_exec", k), {ex_cnt[7:0], 5'd0, ex_op}, {8'd1, 5'd0, alu_tab[k]});
            chk($sformatf("t2_%0d_asel", k), ex_bad, 0);
            chk($sformatf("t2_%0d_sta", k), st_data, res_tab[k]);
            chk($sformatf("t2_%0d_cyc", k), cyc, 14);
        end

        // 3: three wait cycles on every access
        do_reset();
        load_base(8'h30);
        dly = 3;
        go();
        chk("t3_cycles", cyc, 38);
        chk("t3_hold",   hold_bad, 0);
        chk("t3_strobe", {strobe_bad[7:0], lda_cnt[7:0], b_cnt[7:0]}, {8'd0, 8'd1, 8'd1});
        chk("t3_reads",  rd_q.size(), 7);
        chk("t3_sta",    {st_cnt[7:0], st_data}, {8'd1, 8'h08});
        chk("t3_pc",     pc, 4'h5);
        dly = 0;

        // 4: JZ taken / not taken, and z_flag surviving LDB
        do_reset();
        clear_mem();
        mem[0] = 8'h1A; mem[1] = 8'hA7; mem[2] = 8'hF0; mem[7] = 8'hF0; mem[10] = 8'h00;
        go();
        chk("t4a_pc", pc, 4'h8);
        chk("t4a_cyc", cyc, 7);
        do_reset();
        mem[10] = 8'h01;
        go();
        chk("t4b_pc", pc, 4'h3);
        chk("t4b_cyc", cyc, 7);
        do_reset();
        clear_mem();
        mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = 8'hA7; mem[7] = 8'hF0;
        mem[10] = 8'h00; mem[11] = 8'h05;
        go();
        chk("t4c_pc", pc, 4'h8);
        chk("t4c_cyc", cyc, 10);

        // 5: PC wrap F->0 and sticky illegal opcode
        do_reset();
        clear_mem();
        mem[0] = 8'hA4; mem[1] = 8'h1D; mem[2] = 8'h9F; mem[4] = 8'hF0;
        mem[13] = 8'h00; mem[15] = 8'hB0;
        go();
        chk("t5_halt", halted, 1'b1);
        chk("t5_ill",  illegal, 1'b1);
        chk("t5_pc",   pc, 4'h5);
        chk("t5_cyc",  cyc, 13);
        chk("t5_nrd",  rd_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < rd_q.size()) chk($sformatf("t5_rd%0d", i), rd_q[i], exp5[i]);

        // 6: reset during a MEM wait aborts the access
        do_reset();
        chk("t6_ill_clr", illegal, 1'b0);
        load_base(8'h30);
        dly = 3;
        clear_mon();
        run = 1'b1;
        step();
        run = 1'b0;
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 4'hA && !bus.mem_ready) && n < 100) begin
            step();
            n++;
        end
        chk("t6_reach", n < 100, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_req",    bus.mem_req, 1'b0);
        chk("t6_pc",     pc, 4'h0);
        chk("t6_strobe", {a_load, b_load}, 2'b00);
        chk("t6_aluop",  alu_op, 3'b100);
        rst_n = 1'b1;
        step();
        chk("t6_idle", bus.mem_req, 1'b0);
        dly = 0;

        // run is ignored while halted, honoured again after reset
        clear_mem();
        mem[0] = 8'hF0;
        go();
        chk("t6_halted", halted, 1'b1);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("t6_run_ign", {bus.mem_req, halted, pc}, {1'b0, 1'b1, 4'h1});
        do_reset();
        run = 1'b1;
        step();
        run = 1'b0;
        chk("t6_run_ok", {bus.mem_req, bus.mem_addr}, {1'b1, 4'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It sequences the existing 3-bit-op ALU and the external A/B registers, and owns PC, IR and the zero flag. It talks to a shared 16-byte program/data memory through a req/ready handshake. It sits between the memory and the register/ALU datapath and drives every load strobe and the ALU op.

Parameters:
ADDR_W, 4, memory address / PC width
DATA_W, 8, instruction and data width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  start pulse; honoured only in IDLE
mem_req  out  1  memory access request
mem_we  out  1  1=write (data comes from A via datapath), 0=read
mem_addr  out  ADDR_W  access address
mem_ready  in  1  access completes this cycle; mem_rdata valid same cycle
mem_rdata  in  DATA_W  read data
alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV A, 101 MOV B
alu_zero  in  1  ALU result == 0
a_load  out  1  load A this cycle
a_sel  out  1  A source: 0=ALU y, 1=mem_rdata
b_load  out  1  load B from mem_rdata this cycle
pc  out  ADDR_W  current PC
halted  out  1  HLT executed (sticky)
illegal  out  1  undefined opcode decoded (sticky)

Behaviour:
- Instruction format: [7:4] opcode, [3:0] addr.
- Opcodes: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 MOVB (A<=B), 8 STA, 9 JMP, A JZ, F HLT. B–E are illegal.
- Reset (rst_n=0 at an edge): state=IDLE, pc=RESET_PC, ir=0, z_flag=0, halted=0, illegal=0.
- Reset outputs: mem_req=0, mem_we=0, mem_addr=0, a_load=0, b_load=0, a_sel=0, alu_op=100.
- Reset mid-access aborts the access. mem_req is 0 in the first cycle after the reset edge, and no strobe fires.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: all strobes 0. run=1 -> FETCH. run in any other state is ignored.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready. On ready: ir<=mem_rdata, pc<=pc+1 (wraps F->0), -> DECODE.
- DECODE:
  - ALU ops 3–7 -> EXEC.
  - 1, 2, 8 -> MEM.
  - JMP: pc<=addr, -> FETCH.
  - JZ: if z_flag then pc<=addr; -> FETCH.
  - NOP -> FETCH.
  - HLT -> HALT.
  - Illegal: illegal<=1, treated as NOP, -> FETCH.
- EXEC (1 cycle): alu_op from opcode (3->000, 4->001, 5->010, 6->011, 7->101), a_load=1, a_sel=0, z_flag<=alu_zero, -> FETCH.
- MEM: mem_req=1, mem_addr=ir[3:0], mem_we=(opcode==8). Hold until mem_ready. On the ready cycle:
  - LDA: a_load=1, a_sel=1, z_flag<=(mem_rdata==0).
  - LDB: b_load=1.
  - STA: nothing further.
  - Then -> FETCH.
- Load strobes in MEM are combinational on mem_ready (Mealy). All other outputs decode from registered state/ir only.
- HALT: halted=1, all strobes 0. Exit only via reset.
- alu_op is 100 in every state except EXEC.
- mem_req stays high and mem_addr stable while waiting for ready. There are no back-to-back-cycle requests without a new FETCH/MEM entry.
- Minimum latency: ALU op 3 cycles (F, D, E); LDA/LDB/STA 3 (F, D, M); JMP/JZ/NOP 2. Add 1 per wait cycle.
- Boundaries:
  - PC wrap F->0 on fetch.
  - JZ with z_flag=0 falls through.
  - STA/LDA to the instruction's own address are permitted.
  - z_flag is unchanged by LDB, STA, jumps and NOP.

Decomposition:
- Shared header cpu8_defs.vh: opcode constants, ALU op constants (shared with alu), state encodings.
- One sub-module, cpu_decode (combinational): opcode -> {is_alu, alu_op, is_mem, is_store, is_jmp, is_jz, is_hlt, is_illegal}.

Test Plan:
1. Program {0:11 LDA 1? -> use mem: 0:1A, 1:2B, 2:30, 3:8C, 4:F0, A:05, B:03}, run pulse, ready always 1 -> a_load from mem 05, b_load 03, EXEC alu_op=000, STA to C with mem_we=1, halted=1 after 5 instr; total cycles 14.
2. Same program, ALU ops 4/5/6/7 substituted at addr 2 -> alu_op 001/010/011/101 exactly one EXEC cycle each, a_sel=0.
3. Ready delayed 3 cycles on every access -> mem_req held, mem_addr stable, strobes fire only on ready cycle, no PC double increment.
4. LDA of 00 then JZ 7 (7:F0) -> pc=7, halt; repeat with data 01 -> fall through to pc+1.
5. PC at F with NOP at F -> next fetch addr 0. Opcode B fetched -> illegal=1 sticky, execution continues.
6. rst_n low during MEM wait -> next cycle mem_req=0, pc=0, state IDLE; run ignored while halted, accepted after reset.
